// File: rtl/lc3_int_controller.sv
// Multi-channel interrupt controller for the LC-3: edge-latched sources, priority arbitration
// against PSR priority, and a req/ack handshake that presents one vector at a time.
module lc3_int_controller #(
  parameter int          NUM_CH   = 8,
  parameter int          PRIO_W   = 3,
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  VEC_BASE = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq,
  input  logic [PRIO_W-1:0] cur_prio,
  output logic              int_req,
  output logic [PRIO_W-1:0] int_prio,
  output logic [15:0]       int_vector,
  input  logic              int_ack,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [15:0]       io_wdata,
  input  logic              io_we,
  input  logic              io_re,
  output logic [15:0]       io_rdata
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  state_t state_reg;

  logic [NUM_CH-1:0] irq_q_reg;
  logic [NUM_CH-1:0] pending_reg;
  logic [NUM_CH-1:0] pending_next;
  logic [NUM_CH-1:0] cfg_en_reg;
  logic [PRIO_W-1:0] cfg_prio_reg [NUM_CH];
  logic [7:0]        cfg_vec_reg  [NUM_CH];
  logic [15:0]       cfg_word     [NUM_CH];
  logic [NUM_CH-1:0] eligible;
  logic [IDX_W-1:0]  win_idx_reg;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx_next;
  logic [PRIO_W-1:0] win_prio_next;
  logic [7:0]        win_vec_next;

  logic [NUM_CH-1:0] w1c_mask;
  logic [NUM_CH-1:0] ack_mask;
  logic [15:0]       rd_word;
  logic              unused_wdata;

  assign unused_wdata = ^io_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign eligible[gi] = pending_reg[gi] & cfg_en_reg[gi] & (cfg_prio_reg[gi] > cur_prio);
      assign cfg_word[gi] = (16'(cfg_en_reg[gi]) << 15) |
                            (16'(cfg_prio_reg[gi]) << 8) |
                            16'(cfg_vec_reg[gi]);
    end
  endgenerate

  // Highest priority wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    win_found     = 1'b0;
    win_idx_next  = '0;
    win_prio_next = '0;
    win_vec_next  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eligible[i] && (!win_found || (cfg_prio_reg[i] > win_prio_next))) begin
        win_found     = 1'b1;
        win_idx_next  = IDX_W'(i);
        win_prio_next = cfg_prio_reg[i];
        win_vec_next  = cfg_vec_reg[i];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (io_addr == ADDR_W'(i)) begin
        rd_word = cfg_word[i];
      end
    end
    if (io_addr == PEND_ADDR) begin
      rd_word = 16'(pending_reg);
    end
  end

  // A fresh edge always survives a same-cycle clear, whether from W1C or ack.
  always_comb begin
    w1c_mask     = (io_we && (io_addr == PEND_ADDR)) ? io_wdata[NUM_CH-1:0] : '0;
    ack_mask     = ((state_reg == REQ) && int_ack) ? (NUM_CH'(1) << win_idx_reg) : '0;
    pending_next = (pending_reg & ~w1c_mask & ~ack_mask) | (irq & ~irq_q_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q_reg   <= '0;
      pending_reg <= '0;
    end else begin
      irq_q_reg   <= irq;
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_en_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg_prio_reg[i] <= '0;
        cfg_vec_reg[i]  <= '0;
      end
    end else if (io_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (io_addr == ADDR_W'(i)) begin
          cfg_en_reg[i]   <= io_wdata[15];
          cfg_prio_reg[i] <= io_wdata[8 +: PRIO_W];
          cfg_vec_reg[i]  <= io_wdata[7:0];
        end
      end
    end
  end

  // Read data samples pre-write state, so a same-cycle read/write returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_rdata <= '0;
    end else if (io_re) begin
      io_rdata <= rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      win_idx_reg <= '0;
      int_req     <= 1'b0;
      int_prio    <= '0;
      int_vector  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg   <= REQ;
            win_idx_reg <= win_idx_next;
            int_req     <= 1'b1;
            int_prio    <= win_prio_next;
            int_vector  <= {VEC_BASE, win_vec_next};
          end
        end
        REQ: begin
          // Presented request is frozen; it only ends by ack or by losing eligibility.
          if (int_ack) begin
            int_req   <= 1'b0;
            state_reg <= RELEASE;
          end else if (!eligible[win_idx_reg]) begin
            int_req   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RELEASE: begin
          if (!int_ack) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          int_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_int_controller.sv
// Bench for lc3_int_controller: directed vector table, hand sequences for handshake/reset
// corners, then randomized traffic checked cycle-by-cycle against a behavioural model.
module tb_lc3_int_controller;

  localparam int NCH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic [2:0]  cur_prio = '0;
  logic        int_req;
  logic [2:0]  int_prio;
  logic [15:0] int_vector;
  logic        int_ack = 1'b0;
  logic [3:0]  io_addr = '0;
  logic [15:0] io_wdata = '0;
  logic        io_we = 1'b0;
  logic        io_re = 1'b0;
  logic [15:0] io_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  lc3_int_controller #(
    .NUM_CH(8), .PRIO_W(3), .ADDR_W(4), .VEC_BASE(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .cur_prio(cur_prio),
    .int_req(int_req), .int_prio(int_prio), .int_vector(int_vector), .int_ack(int_ack),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural model: sources, config, and whether something is on offer.
  logic [7:0]  m_pend, m_irq_q, m_en;
  logic [2:0]  m_prio [NCH];
  logic [7:0]  m_vec  [NCH];
  logic        m_presenting, m_wait;
  int          m_ch;
  logic [2:0]  m_out_prio;
  logic [15:0] m_out_vec;
  logic [15:0] m_rdata;

  function automatic void model_reset();
    m_pend = '0; m_irq_q = '0; m_en = '0;
    for (int i = 0; i < NCH; i++) begin
      m_prio[i] = '0; m_vec[i] = '0;
    end
    m_presenting = 1'b0; m_wait = 1'b0; m_ch = 0;
    m_out_prio = '0; m_out_vec = '0; m_rdata = '0;
  endfunction

  function automatic bit m_elig(int i);
    return m_pend[i] && m_en[i] && (m_prio[i] > cur_prio);
  endfunction

  function automatic int m_winner();
    for (int p = 7; p >= 1; p--)
      for (int i = 0; i < NCH; i++)
        if (m_elig(i) && (int'(m_prio[i]) == p)) return i;
    return -1;
  endfunction

  function automatic logic [15:0] m_read(int a);
    if (a < NCH) return {m_en[a], 4'b0000, m_prio[a], m_vec[a]};
    if (a == NCH) return {8'h00, m_pend};
    return 16'h0000;
  endfunction

  task automatic model_step();
    logic [7:0] rise;
    logic [7:0] clr;
    int w;
    int a;
    a = int'(io_addr);
    rise = irq & ~m_irq_q;
    clr = '0;
    if (io_re) m_rdata = m_read(a);
    if (m_presenting) begin
      if (int_ack) begin
        clr[m_ch] = 1'b1;
        m_presenting = 1'b0;
        m_wait = 1'b1;
        $display("[TB] ack ch%0d vector %h prio %0d", m_ch, m_out_vec, m_out_prio);
      end else if (!m_elig(m_ch)) begin
        m_presenting = 1'b0;
      end
    end else if (m_wait) begin
      if (!int_ack) m_wait = 1'b0;
    end else begin
      w = m_winner();
      if (w >= 0) begin
        m_presenting = 1'b1;
        m_ch = w;
        m_out_prio = m_prio[w];
        m_out_vec = {8'h01, m_vec[w]};
      end
    end
    if (io_we) begin
      if (a < NCH) begin
        m_en[a] = io_wdata[15];
        m_prio[a] = io_wdata[10:8];
        m_vec[a] = io_wdata[7:0];
      end else if (a == NCH) begin
        clr = clr | io_wdata[7:0];
      end
    end
    m_pend = (m_pend & ~clr) | rise;
    m_irq_q = irq;
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("mdl_req", 16'(int_req), 16'(m_presenting));
    if (m_presenting) begin
      check("mdl_vec", int_vector, m_out_vec);
      check("mdl_prio", 16'(int_prio), 16'(m_out_prio));
    end
    check("mdl_rdata", io_rdata, m_rdata);
  endtask

  task automatic cycle();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic wr(int a, int d);
    io_we = 1'b1; io_addr = 4'(a); io_wdata = 16'(d);
    cycle();
    io_we = 1'b0;
    $display("[TB] write off %0d data %h", a, 16'(d));
  endtask

  task automatic rd(int a, int exp, string name);
    io_re = 1'b1; io_addr = 4'(a);
    cycle();
    io_re = 1'b0;
    check(name, io_rdata, 16'(exp));
    $display("[TB] read off %0d data %h", a, io_rdata);
  endtask

  typedef struct {
    logic        we, re;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  irq;
    logic        ack;
    logic        ereq;
    logic [15:0] evec;
    logic [2:0]  eprio;
    logic        crd;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int we, int re, int a, int d, int q, int ack,
                              int er, int ev, int ep, int cr, int erd);
    vec_t v;
    v.we = 1'(we); v.re = 1'(re); v.addr = 4'(a); v.wdata = 16'(d); v.irq = 8'(q);
    v.ack = 1'(ack); v.ereq = 1'(er); v.evec = 16'(ev); v.eprio = 3'(ep);
    v.crd = 1'(cr); v.erd = 16'(erd);
    return v;
  endfunction

  initial begin
    // Single source: program, pulse, present, ack, pending cleared.
    tbl.push_back(mk(1, 0, 2, 'h8305, 'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h04, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 0, 1, 'h0105, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8, 0, 'h00, 0, 0, 0, 0, 1, 'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 'h0000));
    // Three simultaneous sources: priority then lowest index.
    tbl.push_back(mk(1, 0, 1, 'h8240, 'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 6, 'h8660, 'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3, 'h8630, 'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 0, 1, 'h0130, 6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 0, 1, 'h0160, 6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 0, 1, 'h0140, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h4A, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8, 0, 'h00, 0, 0, 0, 0, 1, 'h0000));
    tbl.push_back(mk(0, 1, 3, 0, 'h00, 0, 0, 0, 0, 1, 'h8630));

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 16'(int_req), 16'h0000);
    check("rst_vec", int_vector, 16'h0000);
    check("rst_prio", 16'(int_prio), 16'h0000);
    check("rst_rdata", io_rdata, 16'h0000);
    rst = 1'b0;

    foreach (tbl[k]) begin
      io_we = tbl[k].we; io_re = tbl[k].re; io_addr = tbl[k].addr;
      io_wdata = tbl[k].wdata; irq = tbl[k].irq; int_ack = tbl[k].ack;
      cycle();
      check("tbl_req", 16'(int_req), 16'(tbl[k].ereq));
      if (tbl[k].ereq) begin
        check("tbl_vec", int_vector, tbl[k].evec);
        check("tbl_prio", 16'(int_prio), 16'(tbl[k].eprio));
      end
      if (tbl[k].crd) check("tbl_rdata", io_rdata, tbl[k].erd);
      $display("[TB] vec %0d req=%0b vector=%h prio=%0d rdata=%h",
               k, int_req, int_vector, int_prio, io_rdata);
    end
    io_we = 1'b0; io_re = 1'b0; int_ack = 1'b0; irq = '0;

    // Masked by current priority, then released by lowering it.
    cur_prio = 3'd4;
    wr(4, 'h8407);
    irq = 8'h10; cycle();
    irq = 8'h00; cycle(); cycle();
    check("t3_noreq", 16'(int_req), 16'h0000);
    rd(8, 'h0010, "t3_pend");
    cur_prio = 3'd3; cycle();
    check("t3_req", 16'(int_req), 16'h0001);
    check("t3_vec", int_vector, 16'h0107);

    // Raising cur_prio withdraws the request but leaves it pending.
    cur_prio = 3'd5; cycle();
    check("t4_withdraw", 16'(int_req), 16'h0000);
    rd(8, 'h0010, "t4_pend");
    wr(8, 'h0010);
    cur_prio = 3'd0;
    rd(8, 'h0000, "t4_w1c");

    // A long ack services exactly one interrupt.
    irq = 8'h14; cycle();
    irq = 8'h00; cycle();
    check("t5_req", 16'(int_req), 16'h0001);
    check("t5_vec", int_vector, 16'h0107);
    int_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_hold", 16'(int_req), 16'h0000);
    end
    int_ack = 1'b0;
    cycle();
    check("t5_gap", 16'(int_req), 16'h0000);
    cycle();
    check("t5_next", 16'(int_req), 16'h0001);
    check("t5_vec2", int_vector, 16'h0105);
    rd(2, 'h8305, "t5_cfg");

    // Asynchronous reset mid-request.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_req", 16'(int_req), 16'h0000);
    check("t6_vec", int_vector, 16'h0000);
    check("t6_prio", 16'(int_prio), 16'h0000);
    check("t6_rdata", io_rdata, 16'h0000);
    irq = 8'hFF;
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("t6_noreq", 16'(int_req), 16'h0000);
    end
    rd(2, 'h0000, "t6_cfg");

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 19) == 0) cur_prio = 3'($urandom);
      if (int_ack) begin
        if ($urandom_range(0, 1) == 0) int_ack = 1'b0;
      end else if (m_presenting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0)) begin
        int_ack = 1'b1;
      end
      io_we = ($urandom_range(0, 9) == 0);
      io_re = ($urandom_range(0, 5) == 0);
      io_addr = 4'($urandom);
      io_wdata = 16'($urandom);
      if ($urandom_range(0, 3) != 0) io_wdata[15] = 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
